// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: HALT opcode, NOP encoding, fetch FSM states
// and the sequential PC increment.
package mips_pkg;

  localparam logic [5:0]  HALT_OPCODE = 6'b010101;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int          PC_INCR     = 4;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: a bubble clears the instruction and valid bit while
// keeping PC+4, a load captures a new fetch, otherwise contents are held.
module ifid_register
  import mips_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bubble,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] next_instr,
  input  logic [PC_WIDTH-1:0]    next_pc4,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc4,
  output logic                   valid
);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= INSTR_WIDTH'(NOP_INSTR);
      pc4   <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= INSTR_WIDTH'(NOP_INSTR);
      valid <= 1'b0;
    end else if (load) begin
      instr <= next_instr;
      pc4   <= next_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS IF stage: PC register, IF/ID register and the RUN/HALTED fetch FSM.
// Optional single-step fetch is enabled by defining FETCH_STEP_EN.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int                PC_WIDTH    = 32,
  parameter int                INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   I_IF_PC_WRITE,
  input  logic                   I_IF_IFID_WRITE,
  input  logic                   I_IF_PC_SRC,
  input  logic [PC_WIDTH-1:0]    I_IF_BRANCH_TARGET,
  input  logic                   I_IF_FLUSH,
  input  logic [INSTR_WIDTH-1:0] I_IF_INSTR,
`ifdef FETCH_STEP_EN
  input  logic                   I_IF_STEP,
`endif
  output logic [PC_WIDTH-1:0]    O_IF_PC,
  output logic [INSTR_WIDTH-1:0] O_IFID_INSTR,
  output logic [PC_WIDTH-1:0]    O_IFID_PC4,
  output logic                   O_IFID_VALID,
  output logic                   O_IF_HALTED
);

  fetch_state_e          state, next_state;
  logic [PC_WIDTH-1:0]   pc, next_pc, pc_plus4;
  logic                  step;
  logic                  capture;
  logic                  halt_seen;
  logic                  ifid_bubble;

`ifdef FETCH_STEP_EN
  assign step = I_IF_STEP;
`else
  assign step = 1'b1;
`endif

  // Wraps modulo 2^PC_WIDTH; the low target bits are never masked.
  assign pc_plus4 = pc + PC_WIDTH'(PC_INCR);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= FETCH_RUN;
      pc    <= RESET_PC;
    end else begin
      state <= next_state;
      pc    <= next_pc;
    end
  end

  // NOTE: every combinational output is defaulted before the if-chain so that
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    next_state  = state;
    next_pc     = pc;
    capture     = (state == FETCH_RUN) && !I_IF_FLUSH && !I_IF_PC_SRC &&
                  step && I_IF_IFID_WRITE;
    halt_seen   = capture && (I_IF_INSTR[INSTR_WIDTH-1 -: 6] == HALT_OPCODE);
    ifid_bubble = I_IF_FLUSH || I_IF_PC_SRC || (state == FETCH_HALTED) || !step;

    if (I_IF_PC_SRC) begin
      // A redirect wins over stall and HALTED: the HALT was on a wrong path.
      next_pc    = I_IF_BRANCH_TARGET;
      next_state = FETCH_RUN;
    end else if (state == FETCH_RUN) begin
      if (halt_seen) begin
        next_state = FETCH_HALTED;
      end else if (I_IF_PC_WRITE && step) begin
        next_pc = pc_plus4;
      end
    end
  end

  ifid_register #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_ifid (
    .clk        (CLK),
    .rst_n      (RESET),
    .bubble     (ifid_bubble),
    .load       (I_IF_IFID_WRITE),
    .next_instr (I_IF_INSTR),
    .next_pc4   (pc_plus4),
    .instr      (O_IFID_INSTR),
    .pc4        (O_IFID_PC4),
    .valid      (O_IFID_VALID)
  );

  assign O_IF_PC     = pc;
  assign O_IF_HALTED = (state == FETCH_HALTED);

endmodule
